// File: rtl/sort_sequencer_pkg.sv
// Shared types and helpers for the sort_sequencer batch sorter.
// Holds the FSM state encoding and the fixed SORT-phase cycle count.
package sort_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bubble sort with DEPTH-1 passes of DEPTH-1 compares each.
    function automatic int unsigned sort_cycles(input int unsigned depth);
        return (depth - 1) * (depth - 1);
    endfunction

endpackage

// File: rtl/sort_sequencer_comparator_lt.sv
// Structural signed less-than: lt = (a < b) in two's complement.
// Built as a ripple-borrow subtractor on offset-binary operands.
module comparator_lt
    import sort_sequencer_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         lt
);

    logic [N-1:0] a_u;
    logic [N-1:0] b_u;
    logic [N:0]   borrow;

    // Flipping the sign bit maps signed order onto unsigned order.
    assign a_u       = {~a[N-1], a[N-2:0]};
    assign b_u       = {~b[N-1], b[N-2:0]};
    assign borrow[0] = 1'b0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_borrow
            assign borrow[gi+1] = (~a_u[gi] & b_u[gi]) |
                                  (~(a_u[gi] ^ b_u[gi]) & borrow[gi]);
        end
    endgenerate

    assign lt = borrow[N];

endmodule

// File: rtl/sort_sequencer.sv
// Batch sorter: loads DEPTH signed words, bubble-sorts them in a fixed
// (DEPTH-1)^2 cycles, then drains them in order. SORT_DESCENDING_EN flips the order.
module sort_sequencer
    import sort_sequencer_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [N-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         busy
);

    localparam int PW          = $clog2(DEPTH);
    localparam int SORT_CYCLES = int'(sort_cycles(DEPTH));
    localparam int CW          = $clog2(SORT_CYCLES + 1);

    state_t         state_q, state_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  j_q, j_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   mem_q [DEPTH];
    logic [N-1:0]   mem_d [DEPTH];
    logic           out_valid_q, out_valid_d;

    logic           in_xfer, out_xfer;
    logic           load_last, drain_last, sort_last;
    logic [PW-1:0]  j_nxt;
    logic [N-1:0]   op_lo, op_hi, cmp_a, cmp_b;
    logic           swap_cond, swap;

    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid_q && out_ready;
    assign load_last  = in_xfer && (wr_ptr_q == PW'(DEPTH - 1));
    assign drain_last = out_xfer && (rd_ptr_q == PW'(DEPTH - 1));
    assign sort_last  = (state_q == ST_SORT) && (cnt_q == CW'(SORT_CYCLES - 1));

    assign j_nxt = j_q + PW'(1);
    assign op_lo = mem_q[j_q];
    assign op_hi = mem_q[j_nxt];

`ifdef SORT_DESCENDING_EN
    assign cmp_a = op_lo;
    assign cmp_b = op_hi;
`else
    assign cmp_a = op_hi;
    assign cmp_b = op_lo;
`endif

    comparator_lt #(.N(N)) u_cmp (
        .a  (cmp_a),
        .b  (cmp_b),
        .lt (swap_cond)
    );

    assign swap = (state_q == ST_SORT) && swap_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_LOAD:  if (load_last)  state_d = ST_SORT;
            ST_SORT:  if (sort_last)  state_d = ST_DRAIN;
            ST_DRAIN: if (drain_last) state_d = ST_LOAD;
            default:                  state_d = ST_LOAD;
        endcase
    end

    // out_valid is registered, so it rises one cycle after DRAIN is entered.
    always_comb begin
        in_ready    = (state_q == ST_LOAD) && !rst;
        busy        = (state_q == ST_SORT);
        out_valid_d = (state_q == ST_DRAIN) && !drain_last;
        out_valid   = out_valid_q;
        out_data    = mem_q[rd_ptr_q];
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        j_d      = j_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (in_xfer) begin
                    mem_d[wr_ptr_q] = in_data;
                    wr_ptr_d        = load_last ? '0 : wr_ptr_q + PW'(1);
                end
            end
            ST_SORT: begin
                if (swap) begin
                    mem_d[j_q]   = op_hi;
                    mem_d[j_nxt] = op_lo;
                end
                j_d   = (j_q == PW'(DEPTH - 2)) ? '0 : j_nxt;
                cnt_d = sort_last ? '0 : cnt_q + CW'(1);
            end
            ST_DRAIN: begin
                if (out_xfer) begin
                    rd_ptr_d = drain_last ? '0 : rd_ptr_q + PW'(1);
                end
            end
            default: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            j_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            j_q         <= j_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            mem_q       <= mem_d;
        end
    end

endmodule

// File: tb/tb_sort_sequencer.sv
// Directed bench for sort_sequencer at N=8, DEPTH=4; honours SORT_DESCENDING_EN.
module tb_sort_sequencer;

    localparam int N     = 8;
    localparam int DEPTH = 4;
`ifdef SORT_DESCENDING_EN
    localparam bit DESC = 1'b1;
`else
    localparam bit DESC = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         busy;

    int compared   = 0;
    int mismatched = 0;

    sort_sequencer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves in_valid high; the caller decides when to drop it.
    task automatic load4(input logic [7:0] w0, input logic [7:0] w1,
                         input logic [7:0] w2, input logic [7:0] w3);
        logic [7:0] w [4];
        w = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = w[i];
            chk("load_in_ready", {31'd0, in_ready}, 32'd1);
            step();
        end
    endtask

    // Called right after the last load edge; returns edges until out_valid.
    task automatic wait_out(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 50; k++) begin
            step();
            if (busy) busy_cycles++;
            if (out_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    // Expected words are given smallest first; descending builds drain them reversed.
    task automatic drain4(input logic [7:0] e0, input logic [7:0] e1,
                          input logic [7:0] e2, input logic [7:0] e3, input bit stall);
        logic [7:0] e [4];
        int idx;
        e = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            idx = DESC ? 3 - i : i;
            if (stall) begin
                out_ready = 1'b0;
                chk("stall_valid_pre", {31'd0, out_valid}, 32'd1);
                chk("stall_data_pre", {24'd0, out_data}, {24'd0, e[idx]});
                step();
                chk("stall_valid_held", {31'd0, out_valid}, 32'd1);
                chk("stall_data_held", {24'd0, out_data}, {24'd0, e[idx]});
            end
            out_ready = 1'b1;
            chk("out_valid", {31'd0, out_valid}, 32'd1);
            chk("out_data", {24'd0, out_data}, {24'd0, e[idx]});
            $display("out word %0d: data=%0d expected=%0d", i, $signed(out_data), $signed(e[idx]));
            step();
        end
        out_ready = 1'b0;
        chk("post_drain_in_ready", {31'd0, in_ready}, 32'd1);
        chk("post_drain_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int edges;
        int bcyc;
        bit seen_valid;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", {24'd0, out_data}, 32'd0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // 3,-1,7,0 -> -1,0,3,7
        load4(8'd3, 8'hFF, 8'd7, 8'd0);
        in_valid = 1'b0;
        wait_out(edges, bcyc);
        chk("lat_b1", edges, 32'd10);
        chk("busy_b1", bcyc, 32'd9);
        drain4(8'hFF, 8'd0, 8'd3, 8'd7, 1'b0);

        // 5,5,-128,127 -> -128,5,5,127
        load4(8'd5, 8'd5, 8'h80, 8'h7F);
        in_valid = 1'b0;
        wait_out(edges, bcyc);
        chk("lat_b2", edges, 32'd10);
        drain4(8'h80, 8'd5, 8'd5, 8'h7F, 1'b0);

        // Already sorted: same fixed duration
        load4(8'd1, 8'd2, 8'd3, 8'd4);
        in_valid = 1'b0;
        wait_out(edges, bcyc);
        chk("lat_b3", edges, 32'd10);
        chk("busy_b3", bcyc, 32'd9);
        drain4(8'd1, 8'd2, 8'd3, 8'd4, 1'b0);

        // Back-pressure with out_ready toggling: 16,-16,32,0 -> -16,0,16,32
        load4(8'h10, 8'hF0, 8'h20, 8'h00);
        in_valid = 1'b0;
        wait_out(edges, bcyc);
        chk("lat_b4", edges, 32'd10);
        drain4(8'hF0, 8'h00, 8'h10, 8'h20, 1'b1);

        // Reset in SORT cycle 4 discards the batch
        load4(8'd4, 8'd3, 8'd2, 8'd1);
        in_valid = 1'b0;
        repeat (3) step();
        chk("mid_sort_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid_rst_out_data", {24'd0, out_data}, 32'd0);
        step();
        rst = 1'b0;
        seen_valid = 1'b0;
        for (int k = 0; k < 15; k++) begin
            step();
            if (out_valid) seen_valid = 1'b1;
        end
        chk("no_partial_output", {31'd0, seen_valid}, 32'd0);
        load4(8'd9, 8'd8, 8'd7, 8'd6);
        in_valid = 1'b0;
        wait_out(edges, bcyc);
        chk("lat_b5", edges, 32'd10);
        drain4(8'd6, 8'd7, 8'd8, 8'd9, 1'b0);

        // in_valid held high with a junk word through SORT and DRAIN
        load4(8'd10, 8'd20, 8'd30, 8'd40);
        in_data = 8'h80;
        wait_out(edges, bcyc);
        chk("lat_b6", edges, 32'd10);
        drain4(8'd10, 8'd20, 8'd30, 8'd40, 1'b0);
        load4(8'h33, 8'h11, 8'h22, 8'h44);
        in_valid = 1'b0;
        wait_out(edges, bcyc);
        chk("lat_b7", edges, 32'd10);
        drain4(8'h11, 8'h22, 8'h33, 8'h44, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sort_sequencer.md
SORT_SEQUENCER -- requirements
Module: sort_sequencer

Interface
REQ-001 Parameter N, default 32: word width in bits; SHALL be >= 2.
REQ-002 Parameter DEPTH, default 8: words per batch; SHALL be a power of two, >= 2.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_data  input  N  signed word to load.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  block accepts a word; transfer = in_valid & in_ready at clock edge.
REQ-008 out_data  output  N  sorted signed word.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  sink accepts; transfer = out_valid & out_ready at clock edge.
REQ-011 busy  output  1  high in SORT state.

Function
REQ-012 FSM states: LOAD, SORT, DRAIN; no other reachable state.
REQ-013 LOAD: in_ready=1, out_valid=0; each input transfer writes in_data to mem[wr_ptr] and increments wr_ptr; the transfer of word DEPTH-1 moves to SORT and clears wr_ptr.
REQ-014 SORT: fixed bubble sort; exactly one signed compare per cycle, of mem[j+1] against mem[j], with j = 0..DEPTH-2 within each pass and DEPTH-1 passes, so SORT lasts exactly (DEPTH-1)^2 cycles.
REQ-015 Ascending swap rule: swap mem[j] and mem[j+1] in the same cycle iff mem[j+1] < mem[j] (signed two's complement); equal words never swap.
REQ-016 After the final compare, the FSM moves to DRAIN; no early exit, and latency is independent of the data.
REQ-017 Latency: if the last input transfers at edge t, out_valid SHALL be high in the cycle beginning at edge t+(DEPTH-1)^2+1.
REQ-018 DRAIN: out_valid=1, out_data=mem[rd_ptr], in_ready=0; each output transfer increments rd_ptr; the transfer of word DEPTH-1 returns the FSM to LOAD and clears rd_ptr.
REQ-019 Back-pressure: while out_ready=0 in DRAIN, out_data and out_valid SHALL hold stable.
REQ-020 in_ready=0 in SORT and DRAIN; in_valid is ignored there.
REQ-021 Pointers and pass counters SHALL wrap only by explicit clearing; no carry into unused bits.
REQ-022 Ascending output order SHALL be smallest first; the most negative value (1 followed by zeros) sorts first.

Reset
REQ-023 While rst=1: state=LOAD, all pointers and counters=0, all mem words=0, in_ready=0, out_valid=0, busy=0, out_data=0.
REQ-024 in_ready SHALL rise in the first cycle after rst deasserts.
REQ-025 Reset asserted mid-LOAD, mid-SORT or mid-DRAIN SHALL discard the batch immediately; no partial output follows.

Configuration
REQ-026 Macro SORT_DESCENDING_EN: when defined, the swap condition SHALL be mem[j] < mem[j+1] and output is largest first; when undefined, ascending order per REQ-015 applies.
REQ-027 Timing, handshakes and latency SHALL be identical with and without SORT_DESCENDING_EN.

Structure
REQ-028 Package sort_sequencer_pkg SHALL hold the FSM state enum typedef and a function computing the SORT cycle count (DEPTH-1)^2.
REQ-029 The single compare SHALL be an instance of the team's structural signed comparator_lt, with N passed through; no other magnitude compare in the block.
REQ-030 The operand mux feeding comparator_lt SHALL select mem[j] and mem[j+1] from the inner counter j.

Verification (N=8, DEPTH=4)
REQ-031 Load 3,-1,7,0 with out_ready=1 -> out -1,0,3,7; out_valid rises 10 edges after the last load; busy high exactly 9 cycles.
REQ-032 Load 5,5,-128,127 -> out -128,5,5,127; with SORT_DESCENDING_EN -> out 127,5,5,-128.
REQ-033 Already-sorted 1,2,3,4 -> out 1,2,3,4 with the same 9-cycle SORT duration.
REQ-034 DRAIN with out_ready toggled 0/1 every cycle -> each word held stable while stalled, 4 transfers, then in_ready=1.
REQ-035 rst pulsed at SORT cycle 4 -> out_valid stays 0; the next batch 9,8,7,6 outputs 6,7,8,9.
REQ-036 in_valid held high throughout SORT and DRAIN -> no extra writes; the next batch starts with the first word presented after re-entering LOAD.
